// File: rtl/cpu_debug_ctrl_if.sv
// Debug state-dump stream: one word per accepted valid/ready beat, last word flagged.
// The master drives the words; the slave supplies ready.
interface cpu_debug_ctrl_if #(
  parameter int DATA_W = 32
) ();
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/cpu_debug_ctrl.sv
// Run-control and state-dump sequencer for the single-cycle CPU: gates execution with a
// clock-enable (run/halt/step/breakpoint) and streams pc, inst and the register file while halted.
module cpu_debug_ctrl #(
  parameter int REG_NUM   = 32,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter bit START_RUN = 1'b1
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              cmd_run,
  input  logic              cmd_halt,
  input  logic              cmd_step,
  input  logic              cmd_dump,
  input  logic              bp_valid,
  input  logic [DATA_W-1:0] bp_addr,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] inst,
  output logic              cpu_ena,
  output logic [ADDR_W-1:0] dbg_raddr,
  input  logic [DATA_W-1:0] dbg_rdata,
  cpu_debug_ctrl_if.master  stream,
  output logic              halted,
  output logic [31:0]       cycle_cnt
);

  typedef enum logic [1:0] {
    ST_HALT,
    ST_RUN,
    ST_STEP,
    ST_DUMP
  } state_t;

  localparam int               IDX_W       = $clog2(REG_NUM + 2);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(REG_NUM + 1);
  localparam state_t           RESET_STATE = START_RUN ? ST_RUN : ST_HALT;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] reg_idx;
  logic             bp_skip;
  logic             bp_hit;

  // The enable must drop in the very cycle of a hit or halt so the instruction is not retired.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    bp_hit  = 1'b0;
    cpu_ena = 1'b0;
    if (state == ST_RUN) begin
      bp_hit  = bp_valid && (pc == bp_addr) && !bp_skip;
      cpu_ena = !bp_hit && !cmd_halt;
    end else if (state == ST_STEP) begin
      cpu_ena = 1'b1;
    end
  end

  // Stream words are a pure decode of idx; pc, inst and the regfile are frozen during DUMP,
  // so the word holds steady under backpressure without an extra register stage.
  always_comb begin
    reg_idx          = idx - IDX_W'(2);
    dbg_raddr        = '0;
    stream.out_valid = 1'b0;
    stream.out_last  = 1'b0;
    stream.out_data  = '0;
    if (state == ST_DUMP) begin
      stream.out_valid = 1'b1;
      stream.out_last  = (idx == LAST_IDX);
      if (idx == IDX_W'(0)) begin
        stream.out_data = pc;
      end else if (idx == IDX_W'(1)) begin
        stream.out_data = inst;
      end else begin
        dbg_raddr       = ADDR_W'(reg_idx);
        stream.out_data = dbg_rdata;
      end
    end
  end

  assign halted = (state == ST_HALT);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state     <= RESET_STATE;
      idx       <= '0;
      bp_skip   <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      if (cpu_ena) begin
        cycle_cnt <= cycle_cnt + 32'd1;
        bp_skip   <= 1'b0;
      end

      unique case (state)
        ST_HALT: begin
          // halt > step > run > dump; a halt while halted simply stays put.
          if (cmd_halt) begin
            state <= ST_HALT;
          end else if (cmd_step) begin
            state   <= ST_STEP;
            bp_skip <= 1'b1;
          end else if (cmd_run) begin
            state   <= ST_RUN;
            bp_skip <= 1'b1;
          end else if (cmd_dump) begin
            state <= ST_DUMP;
            idx   <= '0;
          end
        end
        ST_RUN: begin
          if (cmd_halt || bp_hit) begin
            state <= ST_HALT;
          end
        end
        ST_STEP: begin
          state <= ST_HALT;
        end
        ST_DUMP: begin
          if (stream.out_ready) begin
            if (idx == LAST_IDX) begin
              state <= ST_HALT;
              idx   <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        default: state <= RESET_STATE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Directed bench for cpu_debug_ctrl with a tiny CPU model (pc +4 per enabled cycle,
// inst and regfile contents derived from fixed formulas).
module tb_cpu_debug_ctrl;

  logic        clk_in;
  logic        reset;
  logic        cmd_run, cmd_halt, cmd_step, cmd_dump;
  logic        bp_valid;
  logic [31:0] bp_addr;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        cpu_ena;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;
  logic        halted;
  logic [31:0] cycle_cnt;

  int vectors;
  int miscompares;

  cpu_debug_ctrl_if #(.DATA_W(32)) stream ();

  cpu_debug_ctrl #(
    .REG_NUM  (32),
    .ADDR_W   (5),
    .DATA_W   (32),
    .START_RUN(1'b1)
  ) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .cmd_run  (cmd_run),
    .cmd_halt (cmd_halt),
    .cmd_step (cmd_step),
    .cmd_dump (cmd_dump),
    .bp_valid (bp_valid),
    .bp_addr  (bp_addr),
    .pc       (pc),
    .inst     (inst),
    .cpu_ena  (cpu_ena),
    .dbg_raddr(dbg_raddr),
    .dbg_rdata(dbg_rdata),
    .stream   (stream),
    .halted   (halted),
    .cycle_cnt(cycle_cnt)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h2008_0000;
  endfunction

  function automatic logic [31:0] reg_val(input int i);
    return 32'hA500_0000 | (32'(i) << 8) | 32'(i);
  endfunction

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // CPU model: pc only moves when the controller enables it.
  always @(posedge clk_in or negedge reset) begin
    if (!reset) pc <= 32'h0040_0000;
    else if (cpu_ena) pc <= pc + 32'd4;
  end

  assign inst      = inst_of(pc);
  assign dbg_rdata = reg_val(int'(dbg_raddr));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int cyc;
    logic rdy;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    cmd_run     = 1'b0;
    cmd_halt    = 1'b0;
    cmd_step    = 1'b0;
    cmd_dump    = 1'b0;
    bp_valid    = 1'b0;
    bp_addr     = 32'h0;
    stream.out_ready = 1'b0;

    // Reset values
    repeat (2) @(negedge clk_in);
    check("rst_cycle_cnt", cycle_cnt, 32'd0);
    check("rst_halted", halted, 32'd0);
    check("rst_out_valid", stream.out_valid, 32'd0);
    check("rst_out_last", stream.out_last, 32'd0);
    check("rst_out_data", stream.out_data, 32'd0);
    check("rst_dbg_raddr", dbg_raddr, 32'd0);

    // Free run for 10 cycles
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("run_ena", cpu_ena, 32'd1);
      check("run_halted", halted, 32'd0);
      @(negedge clk_in);
    end
    check("run_cycle_cnt", cycle_cnt, 32'd10);
    check("run_pc", pc, 32'h0040_0028);

    // Breakpoint at 0x00400008 from a fresh reset
    reset = 1'b0;
    #1;
    check("rst2_cycle_cnt", cycle_cnt, 32'd0);
    bp_valid = 1'b1;
    bp_addr  = 32'h0040_0008;
    @(negedge clk_in);
    reset = 1'b1;
    #1;
    check("bp_ena_pc0", cpu_ena, 32'd1);
    @(negedge clk_in);
    check("bp_ena_pc4", cpu_ena, 32'd1);
    @(negedge clk_in);
    check("bp_hit_pc", pc, 32'h0040_0008);
    check("bp_hit_ena", cpu_ena, 32'd0);
    check("bp_hit_not_yet_halted", halted, 32'd0);
    @(negedge clk_in);
    check("bp_halted", halted, 32'd1);
    check("bp_halted_ena", cpu_ena, 32'd0);
    check("bp_halted_pc", pc, 32'h0040_0008);
    check("bp_cycle_cnt", cycle_cnt, 32'd2);
    cmd_run = 1'b1;
    @(negedge clk_in);
    cmd_run = 1'b0;
    check("resume_halted", halted, 32'd0);
    check("resume_ena_at_bp", cpu_ena, 32'd1);
    check("resume_pc", pc, 32'h0040_0008);
    @(negedge clk_in);
    check("resume_pc_adv", pc, 32'h0040_000c);
    check("resume_no_rehalt", cpu_ena, 32'd1);
    check("resume_cycle_cnt", cycle_cnt, 32'd3);

    // Halt and step together in RUN: halt wins, no step
    cmd_halt = 1'b1;
    cmd_step = 1'b1;
    #1;
    check("halt_cmd_ena", cpu_ena, 32'd0);
    @(negedge clk_in);
    cmd_halt = 1'b0;
    cmd_step = 1'b0;
    bp_valid = 1'b0;
    check("halt_halted", halted, 32'd1);
    check("halt_pc", pc, 32'h0040_000c);
    @(negedge clk_in);
    check("halt_no_step_pc", pc, 32'h0040_000c);
    check("halt_no_step_cnt", cycle_cnt, 32'd3);
    check("halt_still", halted, 32'd1);

    // Single step from HALT
    cmd_step = 1'b1;
    @(negedge clk_in);
    cmd_step = 1'b0;
    check("step_ena", cpu_ena, 32'd1);
    check("step_not_halted", halted, 32'd0);
    @(negedge clk_in);
    check("step_back_halted", halted, 32'd1);
    check("step_ena_off", cpu_ena, 32'd0);
    check("step_pc", pc, 32'h0040_0010);
    check("step_cycle_cnt", cycle_cnt, 32'd4);
    @(negedge clk_in);
    check("step_single_pc", pc, 32'h0040_0010);

    // Dump with ready pattern 1,0,0,1,... and a cmd_run that must be ignored
    cmd_dump = 1'b1;
    @(negedge clk_in);
    cmd_dump = 1'b0;
    w   = 0;
    cyc = 0;
    while (w < 34 && cyc < 200) begin
      rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
      stream.out_ready = rdy;
      cmd_run = (cyc == 5);
      check("dump_valid", stream.out_valid, 32'd1);
      check("dump_last", stream.out_last, {31'd0, w == 33});
      check("dump_ena", cpu_ena, 32'd0);
      if (w == 0) check("dump_pc", stream.out_data, 32'h0040_0010);
      else if (w == 1) check("dump_inst", stream.out_data, inst_of(32'h0040_0010));
      else begin
        check("dump_raddr", dbg_raddr, 32'(w - 2));
        check("dump_reg", stream.out_data, reg_val(w - 2));
      end
      @(negedge clk_in);
      if (rdy) w++;
      cyc++;
    end
    stream.out_ready = 1'b0;
    cmd_run = 1'b0;
    check("dump_words", 32'(w), 32'd34);
    check("dump_end_valid", stream.out_valid, 32'd0);
    check("dump_end_halted", halted, 32'd1);
    check("dump_end_pc", pc, 32'h0040_0010);
    check("dump_end_cnt", cycle_cnt, 32'd4);

    // Second dump, reset asserted at word 10
    cmd_dump = 1'b1;
    @(negedge clk_in);
    cmd_dump = 1'b0;
    stream.out_ready = 1'b1;
    w = 0;
    while (w < 10 && w < 50) begin
      @(negedge clk_in);
      w++;
    end
    check("abort_word10", stream.out_data, reg_val(8));
    reset = 1'b0;
    #1;
    check("abort_valid", stream.out_valid, 32'd0);
    check("abort_last", stream.out_last, 32'd0);
    check("abort_halted", halted, 32'd0);
    check("abort_cnt", cycle_cnt, 32'd0);
    stream.out_ready = 1'b0;
    @(negedge clk_in);
    reset = 1'b1;
    #1;
    check("post_rst_ena", cpu_ena, 32'd1);
    check("post_rst_halted", halted, 32'd0);
    @(negedge clk_in);
    check("post_rst_cnt", cycle_cnt, 32'd1);
    check("post_rst_pc", pc, 32'h0040_0004);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
